raxi_rq_mux_arb: RTL and testbench

- Multi-channel RQ egress stage in the pcie_clk domain.
- Takes CH_NUM show-ahead, store-and-forward frame FIFO read ports (one per user engine) and arbitrates whole TLP frames onto a single s_axis_rq stream.
- Decodes the empty-DW count to tkeep, builds tuser byte enables and registers the output with a standard valid/ready handshake.
- Also provides a stall timeout, per-channel end-of-frame pulses and an underrun error.

---
 rtl/raxi_rq_mux_arb.sv | 208 ++++++++++++++++++++
 tb/tb_raxi_rq_mux_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raxi_rq_mux_arb.sv
// RQ egress stage: arbitrates whole TLP frames from CH_NUM show-ahead frame FIFOs onto s_axis_rq.
// Optional build macro RQ_BYTE_SWAP_EN byte-reverses tdata ahead of the output register.
module raxi_rq_mux_arb #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned DW         = 256,
  parameter int unsigned KEEP_W     = DW / 32,
  parameter int unsigned TUSER_W    = 60,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned CLK_PER_US = 250
) (
  input  logic                      pcie_clk,
  input  logic                      pcie_rst,
  input  logic                      pcie_link_up,
  input  logic [CH_NUM-1:0]         ch_empty,
  input  logic [CH_NUM*(DW+16)-1:0] ch_rdata,
  output logic [CH_NUM-1:0]         ch_rd,
  output logic [DW-1:0]             s_axis_rq_tdata,
  output logic [KEEP_W-1:0]         s_axis_rq_tkeep,
  output logic [TUSER_W-1:0]        s_axis_rq_tuser,
  output logic                      s_axis_rq_tlast,
  output logic                      s_axis_rq_tvalid,
  input  logic                      s_axis_rq_tready,
  input  logic [15:0]               reg_tmout_us_cfg,
  output logic                      reg_tmout_us_err,
  output logic [CH_NUM-1:0]         tx_eop_pulse,
  output logic                      underrun_err,
  output logic [CH_NUM-1:0]         cur_grant
);
  localparam int unsigned WW    = DW + 16;
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e              state_q, state_d;
  logic [CH_NUM-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     g_idx, sel_idx;
  logic                sel_found;
  logic                load, eop_pop, starve, starved_q;
  logic [WW-1:0]       head;
  logic [DW-1:0]       in_data, data_nxt;
  logic [3:0]          in_mty, in_fbe, in_lbe;
  logic                in_eop;
  logic [2:0]          unused_rsvd;
  logic [KEEP_W-1:0]   keep_nxt;
  logic [TUSER_W-1:0]  user_nxt;
  logic [DW-1:0]       tdata_q;
  logic [KEEP_W-1:0]   tkeep_q;
  logic [TUSER_W-1:0]  tuser_q;
  logic                tlast_q, tvalid_q;
  logic [CH_NUM-1:0]   eop_pulse_q;
  logic                underrun_q;
  logic                stall;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;

  // rr_ptr_q holds the highest-priority channel for the next round-robin search.
  always_comb begin : p_select
    logic [CH_W-1:0] c;
    c         = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      c = (ARB_MODE == 1) ? CH_W'(k) : CH_W'((32'(rr_ptr_q) + k) % CH_NUM);
      if (!sel_found && !ch_empty[c]) begin
        sel_found = 1'b1;
        sel_idx   = c;
      end
    end
  end

  always_comb begin
    g_idx = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (grant_q[k]) g_idx = CH_W'(k);
    end
  end

  assign head        = ch_rdata[32'(g_idx) * WW +: WW];
  assign in_data     = head[DW-1:0];
  assign in_mty      = head[DW+3:DW];
  assign in_eop      = head[DW+4];
  assign in_fbe      = head[DW+8:DW+5];
  assign in_lbe      = head[DW+12:DW+9];
  assign unused_rsvd = head[DW+15:DW+13];

`ifdef RQ_BYTE_SWAP_EN
  always_comb begin
    data_nxt = in_data;
    for (int unsigned b = 0; b < DW / 8; b++) data_nxt[8*b +: 8] = in_data[DW-8-8*b +: 8];
  end
`else
  assign data_nxt = in_data;
`endif

  always_comb begin
    keep_nxt = {KEEP_W{1'b1}};
    if (in_eop && (32'(in_mty) < KEEP_W)) keep_nxt = {KEEP_W{1'b1}} >> in_mty;
    user_nxt      = '0;
    user_nxt[7:0] = {in_lbe, in_fbe};
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    load     = 1'b0;
    eop_pop  = 1'b0;
    starve   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pcie_link_up && sel_found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          state_d          = StXfer;
        end
      end
      StXfer: begin
        if (!tvalid_q || s_axis_rq_tready) begin
          if (ch_empty[g_idx]) begin
            starve = 1'b1;
          end else begin
            load = 1'b1;
            if (in_eop) begin
              eop_pop  = 1'b1;
              grant_d  = '0;
              state_d  = StIdle;
              rr_ptr_d = (32'(g_idx) == CH_NUM - 1) ? '0 : g_idx + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ch_rd = load ? grant_q : '0;

  // Prescaler only runs during a stall, so the count is whole microseconds of stall.
  assign stall = tvalid_q && !s_axis_rq_tready;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!stall) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (32'(pre_q) == CLK_PER_US - 1) begin
      pre_d = '0;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    err_d = (reg_tmout_us_cfg != 16'd0) && (cnt_d >= reg_tmout_us_cfg);
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      eop_pulse_q <= '0;
      underrun_q  <= 1'b0;
      starved_q   <= 1'b0;
      pre_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= data_nxt;
        tkeep_q  <= keep_nxt;
        tuser_q  <= user_nxt;
        tlast_q  <= in_eop;
      end else if (s_axis_rq_tready) begin
        tvalid_q <= 1'b0;
      end
      eop_pulse_q <= eop_pop ? grant_q : '0;
      underrun_q  <= starve && !starved_q;
      if (load)        starved_q <= 1'b0;
      else if (starve) starved_q <= 1'b1;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign s_axis_rq_tdata  = tdata_q;
  assign s_axis_rq_tkeep  = tkeep_q;
  assign s_axis_rq_tuser  = tuser_q;
  assign s_axis_rq_tlast  = tlast_q;
  assign s_axis_rq_tvalid = tvalid_q;
  assign reg_tmout_us_err = err_q;
  assign tx_eop_pulse     = eop_pulse_q;
  assign underrun_err     = underrun_q;
  assign cur_grant        = grant_q;

endmodule

// File: tb/tb_raxi_rq_mux_arb.sv
// Bench for raxi_rq_mux_arb: queue-based FIFO/arbiter reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_raxi_rq_mux_arb;
  localparam int CH  = 4;
  localparam int DW  = 256;
  localparam int WW  = DW + 16;
  localparam int CPU = 250;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            link_up = 1'b1;
  logic [CH-1:0]   ch_empty = '1;
  logic [CH*WW-1:0] ch_rdata = '0;
  logic [CH-1:0]   ch_rd;
  logic [DW-1:0]   tdata;
  logic [7:0]      tkeep;
  logic [59:0]     tuser;
  logic            tlast, tvalid;
  logic            tready = 1'b1;
  logic [15:0]     cfg = '0;
  logic            tmo_err, underrun;
  logic [CH-1:0]   eop_pulse, cur_grant;

  logic [CH-1:0]    f_empty = '1;
  logic [CH*WW-1:0] f_rdata = '0;
  logic [CH-1:0]    f_rd, f_pulse, f_grant;
  logic [DW-1:0]    f_tdata;
  logic [7:0]       f_tkeep;
  logic [59:0]      f_tuser;
  logic             f_tlast, f_tvalid, f_err, f_under;

  always #2 clk = ~clk;

  raxi_rq_mux_arb #(.CH_NUM(CH), .DW(DW), .ARB_MODE(0), .CLK_PER_US(CPU)) u_rr (
    .pcie_clk(clk), .pcie_rst(rst), .pcie_link_up(link_up), .ch_empty(ch_empty),
    .ch_rdata(ch_rdata), .ch_rd(ch_rd), .s_axis_rq_tdata(tdata), .s_axis_rq_tkeep(tkeep),
    .s_axis_rq_tuser(tuser), .s_axis_rq_tlast(tlast), .s_axis_rq_tvalid(tvalid),
    .s_axis_rq_tready(tready), .reg_tmout_us_cfg(cfg), .reg_tmout_us_err(tmo_err),
    .tx_eop_pulse(eop_pulse), .underrun_err(underrun), .cur_grant(cur_grant)
  );

  raxi_rq_mux_arb #(.CH_NUM(CH), .DW(DW), .ARB_MODE(1), .CLK_PER_US(CPU)) u_fp (
    .pcie_clk(clk), .pcie_rst(rst), .pcie_link_up(1'b1), .ch_empty(f_empty),
    .ch_rdata(f_rdata), .ch_rd(f_rd), .s_axis_rq_tdata(f_tdata), .s_axis_rq_tkeep(f_tkeep),
    .s_axis_rq_tuser(f_tuser), .s_axis_rq_tlast(f_tlast), .s_axis_rq_tvalid(f_tvalid),
    .s_axis_rq_tready(1'b1), .reg_tmout_us_cfg(16'd0), .reg_tmout_us_err(f_err),
    .tx_eop_pulse(f_pulse), .underrun_err(f_under), .cur_grant(f_grant)
  );

  // Reference model state
  logic [WW-1:0] fq [CH][$];
  int            checks = 0;
  int            errors = 0;
  bit            m_busy, m_tv, m_last, m_under, m_starved, m_err, m_pop;
  int            m_g, m_next, m_stall;
  logic [DW-1:0] m_data;
  logic [7:0]    m_keep;
  logic [59:0]   m_user;
  logic [CH-1:0] m_pulse;
  int            grant_log[$];
  int            dut_glog[$];
  logic [CH-1:0] g_prev;
  bit            f_have [CH];
  logic [CH-1:0] f_rd_s, f_prev;
  int            f_log[$];

  function automatic logic [WW-1:0] mk_word(logic [DW-1:0] d, logic [3:0] mty, logic eop,
                                            logic [3:0] fbe, logic [3:0] lbe);
    return {3'b000, lbe, fbe, eop, mty, d};
  endfunction

  function automatic logic [DW-1:0] exp_data(logic [DW-1:0] d);
`ifdef RQ_BYTE_SWAP_EN
    return {<<8{d}};
`else
    return d;
`endif
  endfunction

  // Number of valid DWORDs in the beat, as a contiguous low-aligned mask.
  function automatic logic [7:0] exp_keep(logic eop, logic [3:0] mty);
    int n;
    n = (eop && mty < 8) ? 8 - int'(mty) : 8;
    return 8'((16'd1 << n) - 16'd1);
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < CH; i++) begin
      ch_empty[i] = (fq[i].size() == 0);
      if (fq[i].size() != 0) ch_rdata[i*WW +: WW] = fq[i][0];
      else ch_rdata[i*WW +: WW] = '0;
      f_empty[i] = !f_have[i];
    end
  endtask

  task automatic check_comb();
    m_pop = m_busy && (!m_tv || tready) && (fq[m_g].size() != 0);
    chk("ch_rd", ch_rd, m_pop ? 4'(1 << m_g) : 4'd0);
    f_rd_s = f_rd;
  endtask

  task automatic model_advance();
    logic [WW-1:0] w;
    int pick, us;
    bit was_busy, can_load;
    was_busy = m_busy;
    can_load = !m_tv || tready;
    if (m_tv && !tready) m_stall++;
    else m_stall = 0;
    us = m_stall / CPU;
    if (us > 65535) us = 65535;
    m_err   = (cfg != 0) && (us >= int'(cfg));
    m_pulse = '0;
    m_under = 0;
    if (m_pop) begin
      w         = fq[m_g].pop_front();
      m_tv      = 1;
      m_data    = exp_data(w[DW-1:0]);
      m_keep    = exp_keep(w[DW+4], w[DW+3:DW]);
      m_user    = {52'd0, w[DW+12:DW+9], w[DW+8:DW+5]};
      m_last    = w[DW+4];
      m_starved = 0;
      if (w[DW+4]) begin
        m_pulse[m_g] = 1'b1;
        m_busy       = 0;
        m_next       = (m_g + 1) % CH;
      end
    end else begin
      if (tready) m_tv = 0;
      if (was_busy && can_load) begin
        m_under   = !m_starved;
        m_starved = 1;
      end
    end
    if (!was_busy && link_up) begin
      pick = -1;
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (m_next + k) % CH;
        if (pick < 0 && fq[c].size() != 0) pick = c;
      end
      if (pick >= 0) begin
        m_busy = 1;
        m_g    = pick;
        grant_log.push_back(pick);
      end
    end
    for (int i = 0; i < CH; i++) if (f_rd_s[i]) f_have[i] = 0;
  endtask

  task automatic check_regs();
    chk("tvalid", tvalid, m_tv);
    if (m_tv) begin
      chk("tdata", tdata, m_data);
      chk("tkeep", tkeep, m_keep);
      chk("tuser", tuser, m_user);
      chk("tlast", tlast, m_last);
    end
    chk("tx_eop_pulse", eop_pulse, m_pulse);
    chk("underrun_err", underrun, m_under);
    chk("tmout_err", tmo_err, m_err);
    chk("cur_grant", cur_grant, m_busy ? 4'(1 << m_g) : 4'd0);
    if (cur_grant != 0 && g_prev == 0) dut_glog.push_back(int'(cur_grant));
    g_prev = cur_grant;
    if (f_grant != 0 && f_prev == 0) f_log.push_back(int'(f_grant));
    f_prev = f_grant;
  endtask

  task automatic tick();
    drive_fifos();
    #1;
    check_comb();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; tready = 1; link_up = 1; cfg = '0;
    for (int i = 0; i < CH; i++) begin
      fq[i].delete();
      f_have[i] = 0;
    end
    drive_fifos();
    m_busy = 0; m_tv = 0; m_next = 0; m_g = 0; m_stall = 0; m_err = 0; m_pulse = '0;
    m_under = 0; m_starved = 0; m_pop = 0;
    grant_log.delete(); dut_glog.delete(); f_log.delete(); g_prev = '0; f_prev = '0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tdata", tdata, '0);
    chk("rst_tkeep", tkeep, 8'h00);
    chk("rst_tuser", tuser, 60'd0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_eop", eop_pulse, 4'h0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_err", tmo_err, 1'b0);
    chk("rst_grant", cur_grant, 4'h0);
    rst = 0;
  endtask

  task automatic push_frame(int ch, int len);
    for (int b = 0; b < len; b++)
      fq[ch].push_back(mk_word({8{$urandom()}}, 4'($urandom_range(0, 15)), b == len - 1,
                               4'($urandom()), 4'($urandom())));
  endtask

  initial begin
    logic [DW-1:0] d0;
    bit            tv_at [12];
    logic [7:0]    keep_at [12];
    bit            last_at [12];
    int            p0, p1, p2, uc, highs, adj, first, pushed, sent;
    int            exp_order [8];

    for (int i = 0; i < CH; i++) f_rdata[i*WW +: WW] = mk_word({8{$urandom()}}, 4'd0, 1'b1,
                                                               4'hF, 4'h0);

    // Single channel, 3-beat frame with mty=5 on the last beat
    do_reset();
    d0 = {8{$urandom()}};
    d0[7:0] = 8'hA5;
    fq[0].push_back(mk_word(d0, 4'd9, 1'b0, 4'hF, 4'h1));
    fq[0].push_back(mk_word({8{$urandom()}}, 4'd0, 1'b0, 4'h3, 4'h2));
    fq[0].push_back(mk_word({8{$urandom()}}, 4'd5, 1'b1, 4'h1, 4'hC));
    p0 = 0;
    for (int t = 1; t < 10; t++) begin
      tick();
      tv_at[t] = tvalid; keep_at[t] = tkeep; last_at[t] = tlast;
      p0 += int'(eop_pulse[0]);
      if (t == 2) begin
`ifdef RQ_BYTE_SWAP_EN
        chk("swap_byte", tdata[255:248], 8'hA5);
`else
        chk("pass_byte", tdata[7:0], 8'hA5);
`endif
      end
    end
    chk("lat_tv1", tv_at[1], 1'b0);
    chk("lat_tv2", tv_at[2], 1'b1);
    chk("lat_tv3", tv_at[3], 1'b1);
    chk("lat_tv4", tv_at[4], 1'b1);
    chk("lat_tv5", tv_at[5], 1'b0);
    chk("keep_b1", keep_at[2], 8'hFF);
    chk("keep_b2", keep_at[3], 8'hFF);
    chk("keep_b3", keep_at[4], 8'h07);
    chk("last_b2", last_at[3], 1'b0);
    chk("last_b3", last_at[4], 1'b1);
    chk("eop_cnt0", p0, 1);

    // Round-robin with two single-beat frames per channel
    do_reset();
    for (int r = 0; r < 2; r++) for (int c = 0; c < CH; c++) push_frame(c, 1);
    highs = 0; adj = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (tvalid && tv_at[0]) adj++;
      tv_at[0] = tvalid;
      highs += int'(tvalid);
    end
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("rr_count", dut_glog.size(), 8);
    chk("rr_model_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < dut_glog.size() && i < grant_log.size(); i++) begin
      chk("rr_dut_order", dut_glog[i], 1 << exp_order[i]);
      chk("rr_model_order", grant_log[i], exp_order[i]);
    end
    chk("rr_beats", highs, 8);
    chk("rr_bubble", adj, 0);

    // Fixed priority instance: ch1 and ch2 pending
    f_have[1] = 1; f_have[2] = 1;
    for (int t = 0; t < 8; t++) tick();
    chk("fp_count", f_log.size(), 2);
    if (f_log.size() == 2) begin
      chk("fp_first", f_log[0], 2);
      chk("fp_second", f_log[1], 4);
    end

    // Backpressure and timeout
    do_reset();
    cfg = 16'd3; tready = 0;
    push_frame(0, 1);
    tick(); tick();
    chk("bp_tvalid", tvalid, 1'b1);
    first = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (tmo_err && first < 0) first = k;
    end
    chk("tmo_first", first, 750);
    chk("tmo_held", tmo_err, 1'b1);
    tready = 1;
    tick();
    chk("tmo_clear", tmo_err, 1'b0);
    chk("bp_drained", tvalid, 1'b0);
    cfg = '0;

    // Mid-frame empty, then refill
    do_reset();
    fq[0].push_back(mk_word({8{$urandom()}}, 4'd0, 1'b0, 4'hF, 4'hF));
    uc = 0; p0 = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      uc += int'(underrun);
    end
    chk("underrun_once", uc, 1);
    fq[0].push_back(mk_word({8{$urandom()}}, 4'd0, 1'b0, 4'hF, 4'hF));
    fq[0].push_back(mk_word({8{$urandom()}}, 4'd2, 1'b1, 4'hF, 4'hF));
    for (int t = 0; t < 6; t++) begin
      tick();
      uc += int'(underrun);
      p0 += int'(eop_pulse[0]);
    end
    chk("underrun_total", uc, 1);
    chk("resume_eop", p0, 1);

    // Link drop during a frame
    push_frame(1, 3);
    tick(); tick();
    link_up = 0;
    push_frame(2, 1);
    p1 = 0; p2 = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      p1 += int'(eop_pulse[1]);
      p2 += int'(eop_pulse[2]);
    end
    chk("link_complete", p1, 1);
    chk("link_block", p2, 0);
    chk("link_grant", cur_grant, 4'h0);
    link_up = 1;
    for (int t = 0; t < 5; t++) begin
      tick();
      p2 += int'(eop_pulse[2]);
    end
    chk("link_resume", p2, 1);

    // Randomized traffic
    do_reset();
    cfg = 16'($urandom_range(1, 4));
    pushed = 0; sent = 0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        push_frame($urandom_range(0, CH - 1), $urandom_range(1, 4));
        pushed++;
      end
      tready  = ($urandom_range(0, 9) < 7);
      link_up = ($urandom_range(0, 49) != 0);
      tick();
      for (int i = 0; i < CH; i++) sent += int'(eop_pulse[i]);
    end
    tready = 1; link_up = 1;
    for (int t = 0; t < 600; t++) begin
      tick();
      for (int i = 0; i < CH; i++) sent += int'(eop_pulse[i]);
    end
    chk("rand_frames", sent, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
